// File: rtl/radix4_div_pkg.sv
// radix4_div_pkg: shared definitions for the radix-4 restoring divider.
//   div_state_e  - FSM state encoding (IDLE / RUN / DONE)
//   Digit*       - quotient digit encodings retired per iteration
//   div_iter_w() - width of the iteration counter for a given iteration count
package radix4_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam logic [1:0] DigitZero  = 2'd0;
    localparam logic [1:0] DigitOne   = 2'd1;
    localparam logic [1:0] DigitTwo   = 2'd2;
    localparam logic [1:0] DigitThree = 2'd3;

    // Bits needed to count down from k-1 to 0 (at least one bit).
    function automatic int unsigned div_iter_w(input int unsigned k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/radix4_div18_seq_if.sv
// radix4_div18_seq_if: start/done handshake bundle of the divide unit.
//   start        - request, honoured only when the divider is idle
//   x, y         - dividend / divisor, sampled with an accepted start
//   busy         - iterations in progress
//   done         - one-cycle completion pulse
//   q, r         - quotient / remainder, held until the next completion
//   div_by_zero  - effective divisor was zero
// Modports: master (requester), slave (divider).
interface radix4_div18_seq_if #(
    parameter int unsigned N = 18
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;

    modport master (
        output start, x, y,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/radix4_div_digit.sv
// radix4_div_digit: one radix-4 restoring step (combinational).
//   rem       in  N+2  partial remainder already extended by the next two dividend bits
//   d         in  N    divisor (non-zero)
//   digit     out 2    largest k in {3,2,1,0} with k*d <= rem
//   rem_next  out N+2  rem - digit*d
module radix4_div_digit
    import radix4_div_pkg::*;
#(
    parameter int unsigned N = 18
) (
    input  logic [N+1:0] rem,
    input  logic [N-1:0] d,
    output logic [1:0]   digit,
    output logic [N+1:0] rem_next
);

    logic [N+1:0] d1;
    logic [N+1:0] d2;
    logic [N+1:0] d3;

    assign d1 = {2'b00, d};
    assign d2 = {1'b0, d, 1'b0};
    assign d3 = d1 + d2;  // 3d < 3*2^N, fits in N+2 bits

    always_comb begin
        digit    = DigitZero;
        rem_next = rem;
        if (rem >= d3) begin
            digit    = DigitThree;
            rem_next = rem - d3;
        end else if (rem >= d2) begin
            digit    = DigitTwo;
            rem_next = rem - d2;
        end else if (rem >= d1) begin
            digit    = DigitOne;
            rem_next = rem - d1;
        end
    end

endmodule

// File: rtl/radix4_div18_seq.sv
// radix4_div18_seq: sequential unsigned radix-4 restoring divider, 2 quotient bits per clock.
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   bus (slave) - start/x/y request; busy/done/q/r/div_by_zero response
// A request accepted at edge T completes with done high one cycle after K iterations
// (T+K+1 at the sampling edge); a zero effective divisor completes at T+1 with
// q = all ones, r = x.
// Build option: define DIV_APPROX_EN to clear the low APPROX_BITS divisor bits
// before dividing (falls back to the full divisor if that would make it zero).
// N must be even and at least 4.
module radix4_div18_seq
    import radix4_div_pkg::*;
#(
    parameter int unsigned N           = 18,
    parameter int unsigned APPROX_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    radix4_div18_seq_if.slave bus
);

    localparam int unsigned K    = N / 2;
    localparam int unsigned ItrW = div_iter_w(K);

    div_state_e    state_q, state_d;
    logic [ItrW-1:0] itr_q, itr_d;
    logic [N-1:0]  dvd_q, dvd_d;  // dividend bits not yet consumed, MSB first
    logic [N-1:0]  dsr_q, dsr_d;  // effective divisor
    logic [N-1:0]  rem_q, rem_d;  // partial remainder, always < divisor
    logic [N-1:0]  quo_q, quo_d;  // quotient digits retired so far
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dbz_q, dbz_d;

    logic [N-1:0]  d_eff;
    logic [N+1:0]  rem_shift;
    logic [N+1:0]  rem_next;
    logic [1:0]    digit;
    logic          unused_rem_hi;

`ifdef DIV_APPROX_EN
    localparam logic [N-1:0] KeepMask = {N{1'b1}} << APPROX_BITS;

    always_comb begin
        d_eff = bus.y & KeepMask;
        // Truncation must never turn a non-zero divisor into a divide-by-zero.
        if (d_eff == '0) begin
            d_eff = bus.y;
        end
    end
`else
    localparam int unsigned unused_approx_bits = APPROX_BITS;

    assign d_eff = bus.y;
`endif

    assign rem_shift = {rem_q, dvd_q[N-1:N-2]};

    radix4_div_digit #(
        .N(N)
    ) u_digit (
        .rem      (rem_shift),
        .d        (dsr_q),
        .digit    (digit),
        .rem_next (rem_next)
    );

    // Remainder stays below the divisor, so the top two bits are always zero.
    assign unused_rem_hi = ^rem_next[N+1:N];

    always_comb begin
        state_d = state_q;
        itr_d   = itr_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dvd_d = bus.x;
                    dsr_d = d_eff;
                    if (d_eff == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = bus.x;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        itr_d   = ItrW'(K - 1);
                        rem_d   = '0;
                        quo_d   = '0;
                    end
                end
            end
            StRun: begin
                rem_d = rem_next[N-1:0];
                dvd_d = {dvd_q[N-3:0], 2'b00};
                quo_d = {quo_q[N-3:0], digit};
                itr_d = itr_q - 1'b1;
                if (itr_q == '0) begin
                    state_d = StDone;
                    q_d     = {quo_q[N-3:0], digit};
                    r_d     = rem_next[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            itr_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            itr_q   <= itr_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix4_div18_seq.sv
// tb_radix4_div18_seq: scoreboard bench for radix4_div18_seq (N=18).
// The driver pushes the expected response of every accepted request; a monitor
// pops and compares whenever done is seen. Build with or without DIV_APPROX_EN.
module tb_radix4_div18_seq;

    localparam int unsigned N = 18;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int unsigned  c0;
        int unsigned  lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int n_checks;
    int n_fail;
    exp_t sb[$];
    logic [N-1:0] last_q;
    logic have_last;

    radix4_div18_seq_if #(.N(N)) bus ();

    radix4_div18_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: plain integer division by the effective divisor.
    function automatic exp_t model(input logic [N-1:0] xv, input logic [N-1:0] yv);
        exp_t e;
        logic [N-1:0] d;
        d = yv;
`ifdef DIV_APPROX_EN
        d = yv & 18'h3fff0;
        if (d == '0) d = yv;
`endif
        e.c0 = 0;
        if (d == '0) begin
            e.q = '1; e.r = xv; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = xv / d; e.r = xv % d; e.dbz = 1'b0; e.lat = 10;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", 32'(bus.q), 32'(e.q));
                check("r", 32'(bus.r), 32'(e.r));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("latency", cyc - e.c0, e.lat);
                last_q = e.q;
                have_last = 1'b1;
            end
        end
    end

    task automatic issue(input logic [N-1:0] xv, input logic [N-1:0] yv, input exp_t e);
        exp_t t;
        t = e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = xv;
        bus.y = yv;
        @(posedge clk);
        t.c0 = cyc;
        sb.push_back(t);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 32'(bus.busy), (t.lat == 1) ? 32'd0 : 32'd1);
        if (t.lat != 1 && have_last) check("q_held", 32'(bus.q), 32'(last_q));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_hand(input logic [N-1:0] xv, input logic [N-1:0] yv,
                            input logic [N-1:0] eq, input logic [N-1:0] er,
                            input logic edbz, input int unsigned elat);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.c0 = 0;
        issue(xv, yv, e);
        wait_idle();
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        have_last = 1'b0;
        last_q = '0;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_r", 32'(bus.r), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_hand(18'd100000, 18'd7, 18'd14285, 18'd5, 1'b0, 10);
        run_hand(18'd262143, 18'd1, 18'd262143, 18'd0, 1'b0, 10);
        run_hand(18'd12, 18'd100, 18'd0, 18'd12, 1'b0, 10);
        run_hand(18'd5, 18'd0, 18'd262143, 18'd5, 1'b1, 1);
`ifdef DIV_APPROX_EN
        run_hand(18'd1000, 18'd19, 18'd62, 18'd8, 1'b0, 10);
`else
        run_hand(18'd1000, 18'd19, 18'd52, 18'd12, 1'b0, 10);
`endif

        // Starts during a running op are dropped; only one done may follow.
        e.q = 18'd66666; e.r = 18'd2; e.dbz = 1'b0; e.lat = 10; e.c0 = 0;
        issue(18'd200000, 18'd3, e);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.x = 18'd1; bus.y = 18'd1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.x = 18'd9; bus.y = 18'd0;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of iteration 4.
        e.q = 18'd14285; e.r = 18'd5; e.dbz = 1'b0; e.lat = 10; e.c0 = 0;
        issue(18'd100000, 18'd7, e);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_q", 32'(bus.q), 32'd0);
        check("midreset_r", 32'(bus.r), 32'd0);
        check("midreset_dbz", 32'(bus.div_by_zero), 32'd0);
        sb.delete();
        have_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_hand(18'd100000, 18'd7, 18'd14285, 18'd5, 1'b0, 10);

        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] xv;
            logic [N-1:0] yv;
            xv = N'($urandom);
            case (i % 4)
                0: yv = N'($urandom_range(0, 20));
                1: yv = N'($urandom_range(0, 300));
                default: yv = N'($urandom);
            endcase
            issue(xv, yv, model(xv, yv));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
